// File: rtl/hazard_source_pkg.sv
// rtl/hazard_source_pkg.sv - shared constants and types for the hazard source pipeline
// Purpose: opcode/ALU-op decode constants, exception codes and the fixed
//          destination indices used by the X/M/W write-tracking latches.
// Ports:   none (package).
package hazard_source_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int R_STATUS = 30;
    localparam int R_RA     = 31;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_ADD  = 3'd1,
        EXC_ADDI = 3'd2,
        EXC_SUB  = 3'd3,
        EXC_MUL  = 3'd4,
        EXC_DIV  = 3'd5
    } exc_e;

    // Only the add-class instructions can raise an overflow exception;
    // mul/div carry a code but never redirect their write.
    function automatic logic ovf_eligible(exc_e e);
        return (e == EXC_ADD) || (e == EXC_ADDI) || (e == EXC_SUB);
    endfunction

endpackage

// File: rtl/hazard_source_if.sv
// rtl/hazard_source_if.sv - decode-side forwarding/stall bundle
// Purpose: groups the D-stage inputs, execute/memory results and the
//          X/M/W write indications exchanged with decode control.
// Ports:   master = hazard source (drives x_*/m_*/w_*/loading/overflow),
//          slave  = environment (drives stall/flush/d_*/x_alu/x_ovf/dmem_q).
interface hazard_source_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              stall;
    logic              flush;
    logic [4:0]        d_opcode;
    logic [4:0]        d_aluop;
    logic [REG_W-1:0]  d_rd;
    logic [DATA_W-1:0] x_alu;
    logic              x_ovf;
    logic [DATA_W-1:0] dmem_q;

    logic [REG_W-1:0]  x_rd;
    logic              x_writ;
    logic              x_jal;
    logic              loading;
    logic              overflow;
    logic [DATA_W-1:0] x_res;
    logic [REG_W-1:0]  m_rd;
    logic              m_writ;
    logic              m_jal;
    logic [DATA_W-1:0] m_res;
    logic [REG_W-1:0]  w_rd;
    logic [DATA_W-1:0] w_data;
    logic              w_en;

    modport master (
        input  stall, flush, d_opcode, d_aluop, d_rd, x_alu, x_ovf, dmem_q,
        output x_rd, x_writ, x_jal, loading, overflow, x_res,
               m_rd, m_writ, m_jal, m_res, w_rd, w_data, w_en
    );

    modport slave (
        output stall, flush, d_opcode, d_aluop, d_rd, x_alu, x_ovf, dmem_q,
        input  x_rd, x_writ, x_jal, loading, overflow, x_res,
               m_rd, m_writ, m_jal, m_res, w_rd, w_data, w_en
    );
endinterface

// File: rtl/hazard_source_stage_latch.sv
// rtl/hazard_source_stage_latch.sv - one pipeline latch of the write-tracking bundle
// Purpose: registers a stage record; async reset and synchronous bubble both
//          load an all-zero record (no write, rd 0).
// Ports:   clock, reset (async, active-high), bubble_i, d_i (next record),
//          q_o (current record).
module stage_latch #(
    parameter type T = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic bubble_i,
    input  T     d_i,
    output T     q_o
);

    T rec_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_q <= '0;
        end else if (bubble_i) begin
            rec_q <= '0;
        end else begin
            rec_q <= d_i;
        end
    end

    assign q_o = rec_q;

endmodule

// File: rtl/hazard_source.sv
// rtl/hazard_source.sv - producer end of the decode forwarding/stall interface
// Purpose: decodes the instruction leaving D, tracks its register write through
//          X, M and W, redirects overflowing writes to the status register and
//          drives the register-file write port from W.
// Ports:   clock, reset (async, active-high), hz (hazard_source_if.master).
module hazard_source
    import hazard_source_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    hazard_source_if.master  hz
);

    // X needs no data field: its result is the live ALU output.
    typedef struct packed {
        logic             writ;
        logic [REG_W-1:0] rd;
        logic             jal;
        logic             load;
        exc_e             exc;
    } x_rec_t;

    typedef struct packed {
        logic              writ;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              jal;
        logic              load;
    } m_rec_t;

    typedef struct packed {
        logic              writ;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } w_rec_t;

    x_rec_t x_d, x_q;
    m_rec_t m_d, m_q;
    w_rec_t w_d, w_q;

    logic              bubble;
    logic              ovf;
    logic [DATA_W-1:0] m_res;

    // Stall and flush both just squash the X capture, so asserting both
    // still yields exactly one bubble.
    assign bubble = hz.stall | hz.flush;

    always_comb begin
        x_d    = '0;
        x_d.rd = hz.d_rd;
        case (hz.d_opcode)
            OP_RTYPE: begin
                x_d.writ = 1'b1;
                case (hz.d_aluop)
                    ALU_ADD: x_d.exc = EXC_ADD;
                    ALU_SUB: x_d.exc = EXC_SUB;
                    ALU_MUL: x_d.exc = EXC_MUL;
                    ALU_DIV: x_d.exc = EXC_DIV;
                    default: x_d.exc = EXC_NONE;
                endcase
            end
            OP_ADDI: begin
                x_d.writ = 1'b1;
                x_d.exc  = EXC_ADDI;
            end
            OP_LW: begin
                x_d.writ = 1'b1;
                x_d.load = 1'b1;
            end
            OP_JAL: begin
                x_d.writ = 1'b1;
                x_d.jal  = 1'b1;
                x_d.rd   = REG_W'(R_RA);
            end
            OP_SETX: begin
                x_d.writ = 1'b1;
                x_d.rd   = REG_W'(R_STATUS);
            end
            default: x_d.rd = '0;
        endcase
    end

    stage_latch #(.T(x_rec_t)) u_x_latch (
        .clock    (clock),
        .reset    (reset),
        .bubble_i (bubble),
        .d_i      (x_d),
        .q_o      (x_q)
    );

    // A bubble has writ=0 and exc=NONE, so a stray x_ovf is ignored there.
    assign ovf = hz.x_ovf & x_q.writ & ovf_eligible(x_q.exc);

    always_comb begin
        m_d = '0;
        if (ovf) begin
            m_d.writ = 1'b1;
            m_d.rd   = REG_W'(R_STATUS);
            m_d.data = {{(DATA_W-3){1'b0}}, x_q.exc};
        end else begin
            m_d.writ = x_q.writ;
            m_d.rd   = x_q.rd;
            m_d.data = hz.x_alu;
            m_d.jal  = x_q.jal;
            m_d.load = x_q.load;
        end
    end

    stage_latch #(.T(m_rec_t)) u_m_latch (
        .clock    (clock),
        .reset    (reset),
        .bubble_i (1'b0),
        .d_i      (m_d),
        .q_o      (m_q)
    );

    assign m_res = m_q.load ? hz.dmem_q : m_q.data;

    always_comb begin
        w_d      = '0;
        w_d.writ = m_q.writ;
        w_d.rd   = m_q.rd;
        w_d.data = m_res;
    end

    stage_latch #(.T(w_rec_t)) u_w_latch (
        .clock    (clock),
        .reset    (reset),
        .bubble_i (1'b0),
        .d_i      (w_d),
        .q_o      (w_q)
    );

    assign hz.x_rd     = x_q.rd;
    assign hz.x_writ   = x_q.writ;
    assign hz.x_jal    = x_q.jal;
    assign hz.loading  = x_q.load;
    assign hz.overflow = ovf;
    assign hz.x_res    = hz.x_alu;
    assign hz.m_rd     = m_q.rd;
    assign hz.m_writ   = m_q.writ;
    assign hz.m_jal    = m_q.jal;
    assign hz.m_res    = m_res;
    assign hz.w_rd     = w_q.rd;
    assign hz.w_data   = w_q.data;
    // Register 0 is hardwired; only the regfile port masks it.
    assign hz.w_en     = w_q.writ & (|w_q.rd);

endmodule

// File: tb/tb_hazard_source.sv
// tb/tb_hazard_source.sv - self-checking bench for hazard_source
module tb_hazard_source;

    localparam logic [4:0] NOP   = 5'b00100;
    localparam logic [4:0] RTYPE = 5'b00000;
    localparam logic [4:0] ADDI  = 5'b00101;
    localparam logic [4:0] LW    = 5'b01000;
    localparam logic [4:0] JAL   = 5'b00011;
    localparam logic [4:0] A_ADD = 5'b00000;
    localparam logic [4:0] A_SUB = 5'b00001;
    localparam logic [4:0] A_MUL = 5'b00110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_source_if #(.DATA_W(32), .REG_W(5)) hz ();

    hazard_source #(.DATA_W(32), .REG_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: what each in-flight instruction will eventually do.
    typedef struct { bit writ; bit jal; bit ld; int rd; int code; } xrec_t;
    typedef struct { bit writ; bit jal; bit ld; int rd; int unsigned data; } mrec_t;
    typedef struct { bit en; int rd; int unsigned data; } wrec_t;

    xrec_t mx = '{0, 0, 0, 0, 0};
    mrec_t mm = '{0, 0, 0, 0, 0};
    wrec_t mw = '{0, 0, 0};

    function automatic xrec_t decode(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd);
        xrec_t r = '{0, 0, 0, 0, 0};
        if (op == RTYPE) begin
            r.writ = 1; r.rd = int'(rd);
            r.code = (alu == A_ADD) ? 1 : (alu == A_SUB) ? 3 : (alu == A_MUL) ? 4 :
                     (alu == 5'b00111) ? 5 : 0;
        end else if (op == ADDI) begin
            r.writ = 1; r.rd = int'(rd); r.code = 2;
        end else if (op == LW) begin
            r.writ = 1; r.ld = 1; r.rd = int'(rd);
        end else if (op == JAL) begin
            r.writ = 1; r.jal = 1; r.rd = 31;
        end else if (op == 5'b10101) begin
            r.writ = 1; r.rd = 30;
        end
        return r;
    endfunction

    function automatic bit exp_ovf();
        return hz.x_ovf && mx.writ && (mx.code >= 1) && (mx.code <= 3);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mx = '{0, 0, 0, 0, 0};
            mm = '{0, 0, 0, 0, 0};
            mw = '{0, 0, 0};
        end else begin
            mw.en   = mm.writ && (mm.rd != 0);
            mw.rd   = mm.rd;
            mw.data = mm.ld ? hz.dmem_q : mm.data;
            if (exp_ovf()) mm = '{1, 0, 0, 30, mx.code};
            else           mm = '{mx.writ, mx.jal, mx.ld, mx.rd, hz.x_alu};
            if (hz.stall || hz.flush) mx = '{0, 0, 0, 0, 0};
            else mx = decode(hz.d_opcode, hz.d_aluop, hz.d_rd);
        end
    end

    always @(negedge clock) begin
        chk("x_rd",     32'(hz.x_rd),     32'(mx.rd));
        chk("x_writ",   32'(hz.x_writ),   32'(mx.writ));
        chk("x_jal",    32'(hz.x_jal),    32'(mx.jal));
        chk("loading",  32'(hz.loading),  32'(mx.ld));
        chk("overflow", 32'(hz.overflow), 32'(exp_ovf()));
        chk("x_res",    hz.x_res,         hz.x_alu);
        chk("m_rd",     32'(hz.m_rd),     32'(mm.rd));
        chk("m_writ",   32'(hz.m_writ),   32'(mm.writ));
        chk("m_jal",    32'(hz.m_jal),    32'(mm.jal));
        chk("m_res",    hz.m_res,         mm.ld ? hz.dmem_q : mm.data);
        chk("w_en",     32'(hz.w_en),     32'(mw.en));
        if (mw.en) begin
            chk("w_rd",   32'(hz.w_rd), 32'(mw.rd));
            chk("w_data", hz.w_data,    mw.data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setd(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd);
        hz.d_opcode = op;
        hz.d_aluop  = alu;
        hz.d_rd     = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        hz.stall = 0; hz.flush = 0; hz.x_ovf = 0;
        hz.x_alu = 32'h55; hz.dmem_q = 32'h0;
        setd(NOP, 5'd0, 5'd0);
        repeat (2) tick();
        chk("rst_x_writ", 32'(hz.x_writ), 32'd0);
        chk("rst_m_res",  hz.m_res,       32'd0);
        chk("rst_w_en",   32'(hz.w_en),   32'd0);
        chk("rst_x_res",  hz.x_res,       32'h55);
        reset = 0;

        // addi r5 through the pipe
        setd(ADDI, 5'd0, 5'd5); tick();
        chk("addi_x_rd", 32'(hz.x_rd), 32'd5);
        chk("addi_x_writ", 32'(hz.x_writ), 32'd1);
        setd(NOP, 5'd0, 5'd0); hz.x_alu = 32'h2A; tick();
        chk("addi_m_rd", 32'(hz.m_rd), 32'd5);
        chk("addi_m_res", hz.m_res, 32'h2A);
        hz.x_alu = 32'h0; tick();
        chk("addi_w_en", 32'(hz.w_en), 32'd1);
        chk("addi_w_rd", 32'(hz.w_rd), 32'd5);
        chk("addi_w_data", hz.w_data, 32'h2A);

        // lw r3 followed by a one-cycle stall
        setd(LW, 5'd0, 5'd3); tick();
        chk("lw_loading", 32'(hz.loading), 32'd1);
        hz.stall = 1; setd(ADDI, 5'd0, 5'd9); hz.x_alu = 32'h100; tick();
        hz.stall = 0; setd(NOP, 5'd0, 5'd0); hz.dmem_q = 32'hDEADBEEF; #1;
        chk("stall_x_writ", 32'(hz.x_writ), 32'd0);
        chk("lw_m_rd", 32'(hz.m_rd), 32'd3);
        chk("lw_m_res", hz.m_res, 32'hDEADBEEF);
        tick();
        chk("lw_w_rd", 32'(hz.w_rd), 32'd3);
        chk("lw_w_data", hz.w_data, 32'hDEADBEEF);
        hz.dmem_q = 32'h0;

        // overflow redirection: add, sub, addi
        setd(RTYPE, A_ADD, 5'd7); tick();
        hz.x_ovf = 1; setd(RTYPE, A_SUB, 5'd8); #1;
        chk("add_overflow", 32'(hz.overflow), 32'd1);
        tick();
        chk("add_ovf_m_rd", 32'(hz.m_rd), 32'd30);
        chk("add_ovf_m_res", hz.m_res, 32'd1);
        chk("add_ovf_m_writ", 32'(hz.m_writ), 32'd1);
        setd(ADDI, 5'd0, 5'd9); tick();
        chk("sub_ovf_m_res", hz.m_res, 32'd3);
        setd(RTYPE, A_MUL, 5'd10); tick();
        chk("addi_ovf_m_res", hz.m_res, 32'd2);
        chk("addi_ovf_m_rd", 32'(hz.m_rd), 32'd30);
        chk("mul_no_overflow", 32'(hz.overflow), 32'd0);
        setd(NOP, 5'd0, 5'd0); hz.x_alu = 32'h77; tick();
        chk("mul_m_rd", 32'(hz.m_rd), 32'd10);
        chk("mul_m_res", hz.m_res, 32'h77);
        chk("nop_no_overflow", 32'(hz.overflow), 32'd0);
        hz.x_ovf = 0;

        // flush bubble ignores overflow; stall+flush gives one bubble
        setd(ADDI, 5'd0, 5'd4); hz.flush = 1; tick();
        hz.flush = 0; setd(NOP, 5'd0, 5'd0); hz.x_ovf = 1; #1;
        chk("bubble_overflow", 32'(hz.overflow), 32'd0);
        chk("flush_x_writ", 32'(hz.x_writ), 32'd0);
        hz.x_ovf = 0;
        setd(ADDI, 5'd0, 5'd11); hz.stall = 1; hz.flush = 1; tick();
        hz.stall = 0; hz.flush = 0; setd(NOP, 5'd0, 5'd0);
        chk("both_x_writ", 32'(hz.x_writ), 32'd0);
        tick();

        // jal
        setd(JAL, 5'd0, 5'd12); tick();
        chk("jal_x_jal", 32'(hz.x_jal), 32'd1);
        chk("jal_x_rd", 32'(hz.x_rd), 32'd31);
        setd(NOP, 5'd0, 5'd0); hz.x_alu = 32'h44; tick();
        chk("jal_m_jal", 32'(hz.m_jal), 32'd1);
        tick();
        chk("jal_w_rd", 32'(hz.w_rd), 32'd31);
        chk("jal_w_en", 32'(hz.w_en), 32'd1);
        chk("jal_w_data", hz.w_data, 32'h44);

        // write to r0 and flushed add
        setd(RTYPE, A_ADD, 5'd0); hz.x_alu = 32'h9; tick();
        setd(NOP, 5'd0, 5'd0); tick();
        chk("r0_m_writ", 32'(hz.m_writ), 32'd1);
        chk("r0_m_rd", 32'(hz.m_rd), 32'd0);
        tick();
        chk("r0_w_en", 32'(hz.w_en), 32'd0);
        setd(RTYPE, A_ADD, 5'd6); hz.flush = 1; tick();
        hz.flush = 0; setd(NOP, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_w_en", 32'(hz.w_en), 32'd0);
        end

        // async reset with three writes in flight
        setd(ADDI, 5'd0, 5'd1); tick();
        hz.x_alu = 32'd11; setd(ADDI, 5'd0, 5'd2); tick();
        hz.x_alu = 32'd22; setd(ADDI, 5'd0, 5'd3); tick();
        hz.x_alu = 32'd33; setd(NOP, 5'd0, 5'd0); #1;
        chk("pre_rst_w_en", 32'(hz.w_en), 32'd1);
        #1;
        reset = 1; #1;
        chk("arst_w_en", 32'(hz.w_en), 32'd0);
        chk("arst_x_writ", 32'(hz.x_writ), 32'd0);
        chk("arst_m_writ", 32'(hz.m_writ), 32'd0);
        chk("arst_m_rd", 32'(hz.m_rd), 32'd0);
        chk("arst_w_rd", 32'(hz.w_rd), 32'd0);
        chk("arst_w_data", hz.w_data, 32'd0);
        chk("arst_m_res", hz.m_res, 32'd0);
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_w_en", 32'(hz.w_en), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_source.md
Name: hazard_source

Overview:
- Producer end of the decode-stage forwarding/stall interface.
- Tracks every in-flight register write through the X, M and W pipeline latches.
- Presents the X- and M-stage destination, result, write-enable, jal and load indications that decode-stage control consumes, then drives the register-file write port from W.
- Inserts bubbles on stall/flush and rewrites exception writes to the status register.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register index width
R_STATUS, 30, status register index (overflow/setx target)
R_RA, 31, return-address register index (jal target)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  decode stall; X latch loads a bubble
flush  in  1  taken branch/jump; X latch loads a bubble (same effect as stall)
d_opcode  in  5  opcode of instruction leaving D
d_aluop  in  5  ALU op field of instruction leaving D
d_rd  in  REG_W  rd field of instruction leaving D
x_alu  in  DATA_W  combinational execute result for the X instruction
x_ovf  in  1  combinational ALU overflow for the X instruction
dmem_q  in  DATA_W  data-memory read data for the M instruction
x_rd  out  REG_W  X destination (raw rd; R_RA when jal)
x_writ  out  1  X instruction writes a register
x_jal  out  1  X instruction is jal
loading  out  1  X instruction is lw
overflow  out  1  x_ovf qualified by X valid and add/sub/addi
x_res  out  DATA_W  equals x_alu
m_rd  out  REG_W  M destination, already rewritten for exceptions
m_writ  out  1  M instruction writes a register
m_jal  out  1  M instruction is jal
m_res  out  DATA_W  dmem_q if M is lw, otherwise latched M result
w_rd  out  REG_W  regfile write index
w_data  out  DATA_W  regfile write data
w_en  out  1  regfile write enable

Behaviour:
- Write classes, decoded from d_opcode:
  - 00000 R-type writes rd.
  - 00101 addi writes rd.
  - 01000 lw writes rd and sets load.
  - 00011 jal writes R_RA.
  - 10101 setx writes R_STATUS.
  - All others (sw, j, bne, blt, jr, bex) have writ=0.
- ALU ops of interest: add 00000, sub 00001, mul 00110, div 00111.
- X latch captures the D-side decode on every clock.
  - If stall|flush, it captures a bubble instead: writ=0, jal=0, load=0, rd=0, ovf-eligible=0.
  - The X latch also stores an exception code: add 1, addi 2, sub 3, mul 4, div 5, otherwise 0.
- X to M transfer, every clock:
  - If overflow=1, M takes rd=R_STATUS, result=exception code zero-extended, writ=1, jal=0.
  - Otherwise M takes rd, x_alu, writ, jal, load.
- M to W transfer, every clock:
  - w_data = m_res.
  - w_rd and w_en = m_rd and m_writ.
  - The M and W latches never stall.
- Write to register 0: w_en is forced to 0 whenever w_rd=0. m_writ and x_writ are not masked, because the consumer already filters index 0.
- Latency: an instruction decoded in D appears on the x_* outputs 1 cycle later, on m_* after 2 cycles, and on w_* after 3 cycles.
- Simultaneous stall and flush: a single bubble is inserted; no other effect.
- Reset, asynchronous: all latches clear immediately.
  - All outputs go to 0. Exception: x_res follows x_alu, and m_res follows dmem_q only if m load is set, which is cleared, so m_res is 0.
  - Reset mid-pipeline discards all in-flight writes; no w_en pulse occurs after reset assertion.
- Overflow on an instruction whose X-stage writ=0 (bubble) is ignored.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX);
  - ALU op constants;
  - exception code constants;
  - R_STATUS and R_RA.
- One sub-module, stage_latch: an asynchronous-reset register bundle {valid-writ, rd, data, jal, load, exc} with a synchronous bubble input. It is instantiated for the X, M and W latches.

Test Plan:
- addi r5 decoded, no stall -> next cycle x_rd=5, x_writ=1; +1 cycle m_rd=5; +2 cycles w_en=1, w_rd=5, w_data equals the x_alu value presented (e.g. 0x0000002A).
- lw r3 then stall=1 for one cycle -> loading=1 while lw is in X; next cycle X holds a bubble (x_writ=0), m_rd=3, and m_res equals dmem_q=0xDEADBEEF.
- add r7 with x_ovf=1 -> overflow=1 in X; next cycle m_rd=30, m_res=1, m_writ=1. The sub case gives m_res=3; addi gives m_res=2.
- jal in D -> next cycle x_jal=1, x_rd=31; then m_jal=1; then w_rd=31, w_en=1.
- R-type with rd=0 -> m_writ=1 but w_en=0 at W. Separately, flush=1 with a valid add -> no write reaches W.
- Reset asserted asynchronously mid-cycle with three valid writes in flight -> all outputs 0 immediately and no w_en pulse until new instructions enter.
